// File: rtl/conv_post_process.sv
// -----------------------------------------------------------------------------
// conv_post_process
//
// Post-processing for one convolution output stream. Each accepted adder-tree
// sum (signed Q14.7) gets its per-channel bias added, is saturated to signed
// Q7.7 and passes through a selectable activation. Results queue in a small
// first-word-fall-through FIFO that the output feature-map writer drains with
// a ready/valid handshake.
//
// Pipeline (one result per cycle, no bypass):
//   accept edge N : S1 captures sum/bias/mode
//   edge N+1      : S2 holds the bias-added, saturated value x and its mode
//   edge N+2      : S3 holds the activation result y
//   edge N+3      : y is written to the FIFO
//
// in_ready is a credit signal: it is high only when every result already
// accepted (in flight or buffered) still leaves room for one more, so a FIFO
// write can never meet a full FIFO and the pipeline never has to stall.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   in_valid_i   sum_in_i / bias_in_i / act_mode_i valid
//   sum_in_i     signed adder-tree sum, SUM_W bits, Q14.7
//   bias_in_i    signed bias, BITSIZE bits, Q7.7
//   act_mode_i   0 none, 1 ReLU, 2 ReLU6, 3 h-swish
//   in_ready_o   room guaranteed for one more result
//   out_valid_o  FIFO not empty
//   out_data_o   FIFO head, signed Q7.7 (0 while empty)
//   out_ready_i  consumer takes the head this cycle
//   overflow_o   sticky: an input arrived while in_ready_o was low
// -----------------------------------------------------------------------------
module conv_post_process #(
    parameter int BITSIZE    = 14,
    parameter int SUM_W      = BITSIZE + 7,
    parameter int FRAC       = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    input  logic [SUM_W-1:0]   sum_in_i,
    input  logic [BITSIZE-1:0] bias_in_i,
    input  logic [1:0]         act_mode_i,
    output logic               in_ready_o,
    output logic               out_valid_o,
    output logic [BITSIZE-1:0] out_data_o,
    input  logic               out_ready_i,
    output logic               overflow_o
);

    localparam int S_W      = SUM_W + 1;          // sum + bias never overflows here
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 2;             // holds fifo count + inflight
    localparam int T_W      = FRAC + 4;           // h-swish gate, 0 .. 6.0
    localparam int P_W      = BITSIZE + T_W;      // x * t
    localparam int Q_W      = P_W + 11;           // x * t * 683
    localparam int HS_SHIFT = FRAC + 12;          // drop one Q7 scale and /4096

    localparam logic signed [S_W-1:0]     X_MAX   = S_W'((1 << (BITSIZE - 1)) - 1);
    localparam logic signed [S_W-1:0]     X_MIN   = S_W'(-(1 << (BITSIZE - 1)));
    localparam logic signed [BITSIZE-1:0] XN_MAX  = {1'b0, {(BITSIZE - 1){1'b1}}};
    localparam logic signed [BITSIZE-1:0] XN_MIN  = {1'b1, {(BITSIZE - 1){1'b0}}};
    localparam logic signed [BITSIZE-1:0] RELU6_N = BITSIZE'(6 << FRAC);
    localparam logic signed [BITSIZE+1:0] HS_OFF  = (BITSIZE + 2)'(3 << FRAC);
    localparam logic signed [BITSIZE+1:0] HS_CAP  = (BITSIZE + 2)'(6 << FRAC);
    localparam logic signed [Q_W-1:0]     HS_MUL  = Q_W'(683);   // ~4096/6
    localparam logic signed [Q_W-1:0]     Q_MAX   = Q_W'((1 << (BITSIZE - 1)) - 1);
    localparam logic signed [Q_W-1:0]     Q_MIN   = Q_W'(-(1 << (BITSIZE - 1)));

    // ------------------------------------------------------------------ state
    logic                      s1_valid_q, s2_valid_q, s3_valid_q;
    logic signed [SUM_W-1:0]   s1_sum_q;
    logic signed [BITSIZE-1:0] s1_bias_q;
    logic [1:0]                s1_mode_q, s2_mode_q;
    logic signed [BITSIZE-1:0] s2_x_q, s3_y_q;

    logic [BITSIZE-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      overflow_q;

    // ------------------------------------------------------------ handshakes
    logic          accept, push, pop;
    logic [CW-1:0] inflight;

    assign inflight    = CW'(s1_valid_q) + CW'(s2_valid_q) + CW'(s3_valid_q);
    assign in_ready_o  = (cnt_q + inflight) < CW'(FIFO_DEPTH);
    assign accept      = in_valid_i & in_ready_o;
    assign push        = s3_valid_q;
    assign out_valid_o = (cnt_q != '0);
    assign pop         = out_valid_o & out_ready_i;
    assign overflow_o  = overflow_q;
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

    // ----------------------------------------------- S1 -> S2: bias + sat14
    logic signed [S_W-1:0]     s1_s;
    logic signed [BITSIZE-1:0] s1_x;

    assign s1_s = $signed({s1_sum_q[SUM_W-1], s1_sum_q})
                + $signed({{(S_W - BITSIZE){s1_bias_q[BITSIZE-1]}}, s1_bias_q});

    always_comb begin
        s1_x = s1_s[BITSIZE-1:0];
        if (s1_s > X_MAX) begin
            s1_x = XN_MAX;
        end else if (s1_s < X_MIN) begin
            s1_x = XN_MIN;
        end
    end

    // ------------------------------------------------- S2 -> S3: activation
    logic signed [BITSIZE+1:0] hs_sum;
    logic [T_W-1:0]            hs_t;
    logic signed [P_W-1:0]     hs_p;
    logic signed [Q_W-1:0]     hs_q, hs_sh;
    logic signed [BITSIZE-1:0] hs_y, relu_y, relu6_y, act_y;

    assign hs_sum = $signed({{2{s2_x_q[BITSIZE-1]}}, s2_x_q}) + HS_OFF;

    always_comb begin
        hs_t = T_W'(hs_sum);
        if (hs_sum < 0) begin
            hs_t = '0;
        end else if (hs_sum > HS_CAP) begin
            hs_t = T_W'(HS_CAP);
        end
    end

    // t is unsigned, so it is zero-extended before the signed multiply.
    assign hs_p  = $signed({{(P_W - BITSIZE){s2_x_q[BITSIZE-1]}}, s2_x_q})
                 * $signed({{(P_W - T_W){1'b0}}, hs_t});
    assign hs_q  = $signed({{(Q_W - P_W){hs_p[P_W-1]}}, hs_p}) * HS_MUL;
    assign hs_sh = hs_q >>> HS_SHIFT;   // arithmetic shift floors negatives

    always_comb begin
        hs_y = hs_sh[BITSIZE-1:0];
        if (hs_sh > Q_MAX) begin
            hs_y = XN_MAX;
        end else if (hs_sh < Q_MIN) begin
            hs_y = XN_MIN;
        end
    end

    assign relu_y  = s2_x_q[BITSIZE-1] ? '0 : s2_x_q;
    assign relu6_y = (relu_y > RELU6_N) ? RELU6_N : relu_y;

    always_comb begin
        act_y = s2_x_q;
        case (s2_mode_q)
            2'd1:    act_y = relu_y;
            2'd2:    act_y = relu6_y;
            2'd3:    act_y = hs_y;
            default: act_y = s2_x_q;
        endcase
    end

    // ------------------------------------------------------ pipeline stages
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_bias_q  <= '0;
            s1_mode_q  <= '0;
            s2_x_q     <= '0;
            s2_mode_q  <= '0;
            s3_y_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_sum_q  <= $signed(sum_in_i);
                s1_bias_q <= $signed(bias_in_i);
                s1_mode_q <= act_mode_i;
            end
            s2_valid_q <= s1_valid_q;
            s2_x_q     <= s1_x;
            s2_mode_q  <= s1_mode_q;
            s3_valid_q <= s2_valid_q;
            s3_y_q     <= act_y;
            // Rejected inputs are dropped, never stalled; remember that it happened.
            if (in_valid_i && !in_ready_o) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ FWFT FIFO
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                mem_q[wr_ptr_q] <= s3_y_q;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_post_process.sv
// -----------------------------------------------------------------------------
// tb_conv_post_process
//
// Self-checking bench for conv_post_process. A reference model computes each
// result from the arithmetic rules with plain integers and tracks every
// accepted-but-not-yet-consumed result in a queue together with the cycle at
// which it becomes visible. in_ready, out_valid, out_data and overflow are
// compared against that model every cycle; directed tables and sequences
// cover saturation, activations, latency, backpressure and mid-run reset.
// -----------------------------------------------------------------------------
module tb_conv_post_process;

    localparam int BITSIZE = 14;
    localparam int SUM_W   = BITSIZE + 7;
    localparam int DEPTH   = 4;
    localparam int LAT     = 3;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               in_valid_i = 1'b0;
    logic [SUM_W-1:0]   sum_in_i = '0;
    logic [BITSIZE-1:0] bias_in_i = '0;
    logic [1:0]         act_mode_i = '0;
    logic               in_ready_o;
    logic               out_valid_o;
    logic [BITSIZE-1:0] out_data_o;
    logic               out_ready_i = 1'b0;
    logic               overflow_o;

    conv_post_process #(
        .BITSIZE   (BITSIZE),
        .SUM_W     (SUM_W),
        .FRAC      (7),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .sum_in_i   (sum_in_i),
        .bias_in_i  (bias_in_i),
        .act_mode_i (act_mode_i),
        .in_ready_o (in_ready_o),
        .out_valid_o(out_valid_o),
        .out_data_o (out_data_o),
        .out_ready_i(out_ready_i),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- model
    typedef struct {
        int data;
        int ready_at;
    } exp_t;

    typedef struct {
        int sum;
        int bias;
        int mode;
        int exp;
    } vec_t;

    exp_t model_q[$];
    int   popq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   exp_ovf = 1'b0;
    int   first_valid_cyc = -1;

    function automatic int clampi(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Result from the arithmetic definition: bias add, saturate, activate.
    function automatic int ref_y(int sum, int bias, int mode);
        int     x;
        int     t;
        longint q;
        longint d;
        x = clampi(sum + bias, -8192, 8191);
        case (mode)
            0: return x;
            1: return (x > 0) ? x : 0;
            2: return clampi(x, 0, 768);
            default: begin
                t = clampi(x + 384, 0, 768);
                q = longint'(x) * t * 683;
                d = q / 524288;
                if (q < 0 && (q % 524288) != 0) d = d - 1;   // floor, not truncate
                return clampi(int'(d), -8192, 8191);
            end
        endcase
    endfunction

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // One clock cycle: drive inputs, check outputs at the negedge, then
    // advance the model at the active edge.
    task automatic drive(input bit v, input int s, input int b, input int m, input bit ordy);
        bit er;
        bit ev;
        int dv;
        in_valid_i  = v;
        sum_in_i    = s[SUM_W-1:0];
        bias_in_i   = b[BITSIZE-1:0];
        act_mode_i  = m[1:0];
        out_ready_i = ordy;
        @(negedge clk_i);
        er = (model_q.size() < DEPTH);
        ev = (model_q.size() > 0) && (model_q[0].ready_at <= cyc);
        chk("in_ready", int'(in_ready_o), int'(er));
        chk("out_valid", int'(out_valid_o), int'(ev));
        chk("overflow", int'(overflow_o), int'(exp_ovf));
        dv = int'($signed(out_data_o));
        if (ev) chk("out_data", dv, model_q[0].data);
        if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid_o && ordy) begin
            popq.push_back(dv);
            $display("pop data=%0d cycle=%0d", dv, cyc);
        end
        @(posedge clk_i);
        if (v && er) model_q.push_back('{data: ref_y(s, b, m), ready_at: cyc + 1 + LAT});
        if (v && !er) exp_ovf = 1'b1;
        if (ev && ordy) void'(model_q.pop_front());
        cyc++;
        #1;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 0, ordy);
    endtask

    // Reset asserted between edges: outputs must react immediately.
    task automatic do_reset();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_overflow", int'(overflow_o), 0);
        chk("rst_in_ready", int'(in_ready_o), 1);
        chk("rst_out_data", int'($signed(out_data_o)), 0);
        model_q.delete();
        exp_ovf = 1'b0;
        @(posedge clk_i);
        #1;
        chk("rst_hold_out_valid", int'(out_valid_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    vec_t vecs[14];

    initial begin
        int acc_edge;
        int i;
        int s;
        int b;

        vecs[0]  = '{-11232,   0, 0, -8192};   // saturate low
        vecs[1]  = '{-11232,   0, 1,     0};
        vecs[2]  = '{   640, 128, 0,   768};   // bias add
        vecs[3]  = '{   640, 128, 2,   768};
        vecs[4]  = '{   640, 128, 3,   768};
        vecs[5]  = '{  1000,   0, 2,   768};   // ReLU6 clamp
        vecs[6]  = '{  -128,   0, 3,   -43};   // h-swish floors negatives
        vecs[7]  = '{  -384,   0, 3,     0};
        vecs[8]  = '{ -1000,   0, 3,     0};
        vecs[9]  = '{  8191,   0, 3,  8191};   // h-swish saturates
        vecs[10] = '{   256,   0, 3,   213};
        vecs[11] = '{  -200,   0, 3,   -48};
        vecs[12] = '{1048575, 8191, 0,  8191}; // saturate high
        vecs[13] = '{   300,-500, 1,     0};

        do_reset();

        // ---- table: one result at a time, check the popped value
        foreach (vecs[k]) begin
            popq.delete();
            drive(1'b1, vecs[k].sum, vecs[k].bias, vecs[k].mode, 1'b1);
            for (int w = 0; w < 10 && popq.size() == 0; w++) drive(1'b0, 0, 0, 0, 1'b1);
            chk($sformatf("vec%0d_pops", k), popq.size(), 1);
            if (popq.size() > 0) chk($sformatf("vec%0d_data", k), popq[0], vecs[k].exp);
        end

        // ---- latency and ordering: 1..10, producer follows in_ready
        popq.delete();
        first_valid_cyc = -1;
        acc_edge = -1;
        i = 1;
        for (int w = 0; w < 80 && i <= 10; w++) begin
            if (model_q.size() < DEPTH) begin
                if (i == 1) acc_edge = cyc + 1;
                drive(1'b1, i, 0, 0, 1'b1);
                i++;
            end else begin
                drive(1'b0, 0, 0, 0, 1'b1);
            end
        end
        for (int w = 0; w < 20 && popq.size() < 10; w++) drive(1'b0, 0, 0, 0, 1'b1);
        chk("t4_latency", first_valid_cyc, acc_edge + LAT);
        chk("t4_count", popq.size(), 10);
        for (int k = 0; k < 10 && k < popq.size(); k++) chk($sformatf("t4_order%0d", k), popq[k], k + 1);

        // ---- backpressure: 6 offered, 4 accepted, 2 dropped
        popq.delete();
        for (int k = 1; k <= 6; k++) drive(1'b1, k, 0, 0, 1'b0);
        chk("t5_in_ready_low", int'(in_ready_o), 0);
        chk("t5_overflow", int'(overflow_o), 1);
        idle(12, 1'b1);
        chk("t5_count", popq.size(), 4);
        for (int k = 0; k < 4 && k < popq.size(); k++) chk($sformatf("t5_order%0d", k), popq[k], k + 1);
        chk("t5_in_ready_back", int'(in_ready_o), 1);

        // ---- reset mid-operation: FIFO holds 2, 2 still in flight
        popq.delete();
        for (int k = 0; k < 4; k++) drive(1'b1, 100 + k, 0, 0, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0);
        chk("t6_pre_valid", int'(out_valid_o), 1);
        do_reset();
        drive(1'b1, 55, 0, 0, 1'b1);
        idle(8, 1'b1);
        chk("t6_count", popq.size(), 1);
        if (popq.size() > 0) chk("t6_data", popq[0], 55);

        // ---- randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 1) == 0) s = int'($urandom_range(0, 2097151)) - 1048576;
            else                           s = int'($urandom_range(0, 24000)) - 12000;
            b = int'($urandom_range(0, 16383)) - 8192;
            drive($urandom_range(0, 3) != 0, s, b, int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0);
        end
        idle(12, 1'b1);
        chk("final_empty", int'(out_valid_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
